// File: rtl/serial_deserializer.sv
// Oversampling serial receiver: frames start/data/stop bits at DIV clocks per bit and
// presents each accepted word on data_out with a one-cycle done strobe. Define
// DESER_PARITY_EN to add an even-parity bit after the data bits.
module serial_deserializer #(
    parameter int WORD_W = 16,
    parameter int DIV    = 100
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              serial_in,
    output logic [WORD_W-1:0] data_out,
    output logic              done,
    output logic              busy,
    output logic              frame_err,
    output logic              parity_err
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = $clog2(WORD_W + 2);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(DIV / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef DESER_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_FIN    = 3'd5
    } state_t;

`ifdef DESER_PARITY_EN
    function automatic logic even_parity(input logic [WORD_W-1:0] word);
        even_parity = ^word;
    endfunction
`endif

    state_t              state_r;
    state_t              state_nx_s;
    logic                sync1_r;
    logic                rx_r;
    logic [DIV_W-1:0]    div_cnt_r;
    logic [BIT_W-1:0]    bit_cnt_r;
    logic [WORD_W-1:0]   shift_r;
    logic                stop_r;
    logic                par_mis_s;
    logic                div_last_s;
    logic                div_half_s;
    logic                bit_last_s;

    logic [WORD_W-1:0]   data_r;
    logic [WORD_W-1:0]   data_nx_s;
    logic                done_r;
    logic                done_s;
    logic                busy_r;
    logic                busy_s;
    logic                frame_err_r;
    logic                frame_err_s;
    logic                parity_err_s;

    assign div_last_s = (div_cnt_r == DIV_LAST);
    assign div_half_s = (div_cnt_r == DIV_HALF);
    assign bit_last_s = (bit_cnt_r == BIT_LAST);

    // Two-flop synchronizer for the asynchronous line; resets to the idle level.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r <= 1'b1;
            rx_r    <= 1'b1;
        end else begin
            sync1_r <= serial_in;
            rx_r    <= sync1_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic; dropping enable forces IDLE from any state.
    always_comb begin
        state_nx_s = state_r;
        if (!enable) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!rx_r) begin
                        state_nx_s = ST_START;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (div_half_s) begin
                        state_nx_s = rx_r ? ST_IDLE : ST_DATA;
                    end else begin
                        state_nx_s = ST_START;
                    end
                end
                ST_DATA: begin
                    if (div_last_s && bit_last_s) begin
`ifdef DESER_PARITY_EN
                        state_nx_s = ST_PARITY;
`else
                        state_nx_s = ST_STOP;
`endif
                    end else begin
                        state_nx_s = ST_DATA;
                    end
                end
`ifdef DESER_PARITY_EN
                ST_PARITY: begin
                    if (div_last_s) begin
                        state_nx_s = ST_STOP;
                    end else begin
                        state_nx_s = ST_PARITY;
                    end
                end
`endif
                ST_STOP: begin
                    if (div_last_s) begin
                        state_nx_s = ST_FIN;
                    end else begin
                        state_nx_s = ST_STOP;
                    end
                end
                ST_FIN: begin
                    state_nx_s = ST_IDLE;
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end
    end

    // Bit-timing counters, shift register and captured stop/parity samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt_r <= '0;
            bit_cnt_r <= '0;
            shift_r   <= '0;
            stop_r    <= 1'b0;
        end else if (!enable) begin
            div_cnt_r <= '0;
            bit_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_START: begin
                    bit_cnt_r <= '0;
                    if (div_half_s) begin
                        div_cnt_r <= '0;
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_W'(1);
                    end
                end
                ST_DATA: begin
                    if (div_last_s) begin
                        div_cnt_r <= '0;
                        shift_r   <= {rx_r, shift_r[WORD_W-1:1]};
                        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_W'(1);
                    end
                end
`ifdef DESER_PARITY_EN
                ST_PARITY: begin
                    if (div_last_s) begin
                        div_cnt_r <= '0;
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_W'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (div_last_s) begin
                        div_cnt_r <= '0;
                        stop_r    <= rx_r;
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_W'(1);
                    end
                end
                default: begin
                    div_cnt_r <= '0;
                    bit_cnt_r <= '0;
                end
            endcase
        end
    end

`ifdef DESER_PARITY_EN
    logic par_mis_r;
    logic parity_err_r;

    // Parity mismatch flag, sampled once per frame in the PARITY bit period.
    always_ff @(posedge clock) begin
        if (reset) begin
            par_mis_r <= 1'b0;
        end else if (enable && (state_r == ST_PARITY) && div_last_s) begin
            par_mis_r <= rx_r ^ even_parity(shift_r);
        end else if (state_r == ST_IDLE) begin
            par_mis_r <= 1'b0;
        end else begin
            par_mis_r <= par_mis_r;
        end
    end

    // Registered parity error strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            parity_err_r <= 1'b0;
        end else begin
            parity_err_r <= parity_err_s;
        end
    end

    assign par_mis_s  = par_mis_r;
    assign parity_err = parity_err_r;
`else
    assign par_mis_s  = 1'b0;
    assign parity_err = 1'b0;
`endif

    // FSM output logic: one frame outcome per FIN cycle, stop-bit error takes priority.
    always_comb begin
        done_s       = 1'b0;
        frame_err_s  = 1'b0;
        parity_err_s = 1'b0;
        data_nx_s    = data_r;
        busy_s       = (state_nx_s != ST_IDLE);
        if (enable && (state_r == ST_FIN)) begin
            if (!stop_r) begin
                frame_err_s = 1'b1;
            end else if (par_mis_s) begin
                parity_err_s = 1'b1;
            end else begin
                done_s    = 1'b1;
                data_nx_s = shift_r;
            end
        end else begin
            data_nx_s = data_r;
        end
    end

    // Output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_r      <= '0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            data_r      <= data_nx_s;
            done_r      <= done_s;
            busy_r      <= busy_s;
            frame_err_r <= frame_err_s;
        end
    end

    assign data_out  = data_r;
    assign done      = done_r;
    assign busy      = busy_r;
    assign frame_err = frame_err_r;

endmodule

// File: doc/serial_deserializer.md
# serial_deserializer

Serial receive front end for the capture path: oversamples an asynchronous, idle-high serial line on the 100 MHz system clock, frames start/data/stop bits at a fixed bit rate (1 Mbit/s by default), and assembles each frame into a parallel word. Each accepted word is presented on `data_out` with a single-cycle `done` strobe. `done` drives the memory address counter's `done` input and the memory write-enable directly downstream.

## Interface
- `WORD_W`, 16: data bits per frame, LSB first; ≥ 2.
- `DIV`, 100: system clocks per bit period; even, ≥ 4.

- `clock` in 1: system clock (100 MHz); all logic on rising edge.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `enable` in 1: receiver run; low aborts any frame and holds the block idle.
- `serial_in` in 1: asynchronous serial line, idle high.
- `data_out` out `WORD_W`: last accepted word; held between `done` pulses.
- `done` out 1: one-cycle pulse, `data_out` valid and new.
- `busy` out 1: high from start-bit detect until return to IDLE.
- `frame_err` out 1: one-cycle pulse, stop bit sampled low; word discarded.
- `parity_err` out 1: one-cycle pulse (only with `DESER_PARITY_EN`, else tied 0).

## Operation
- `serial_in` passes a 2-flop synchronizer; all decisions use synchronized value `rx`.
- Bit counter `bit_cnt` (clog2(WORD_W+2) bits); divider counter `div_cnt` counts 0..DIV-1, wrapping to 0.
- FSM states:
  - IDLE: `div_cnt`=0, `busy`=0. `rx`==0 && `enable` → START, `div_cnt` cleared.
  - START: at `div_cnt`==DIV/2-1 re-sample `rx`. If 0 → DATA, `div_cnt`=0, `bit_cnt`=0. If 1 → IDLE (glitch rejected, no pulse).
  - DATA: at each `div_cnt`==DIV-1, shift `rx` into shift register at MSB, so after WORD_W samples bit 0 is at LSB. Increment `bit_cnt`. After the WORD_W-th sample → PARITY if macro enabled, else STOP.
  - PARITY: one sample at `div_cnt`==DIV-1; store mismatch flag → STOP.
  - STOP: sample at `div_cnt`==DIV-1, then → IDLE:
    - `rx`==1 and no parity mismatch: `data_out` ← shift register; `done` pulses.
    - `rx`==0: `frame_err` pulses; `data_out` unchanged.
    - `rx`==1 with mismatch: `parity_err` pulses; `data_out` unchanged.
- Stop low with parity mismatch reports `frame_err` only.
- `enable` low in any state: next cycle IDLE, counters cleared, no pulse. `data_out` retained.
- Line held low after a frame error: IDLE re-detects immediately. No break detection.

## Timing
- Reset values: `data_out`=0, `done`=0, `busy`=0, `frame_err`=0, `parity_err`=0, FSM=IDLE, counters 0, synchronizer flops=1.
- Reset mid-frame: all of the above on the next edge. No pulse is emitted.
- Let t0 = the edge where IDLE sees `rx`==0. This is 2–3 clocks after the pin falls.
- Start check at t0+DIV/2.
- Data bit i sampled at t0+DIV/2+(i+1)·DIV.
- Stop sampled at t0+DIV/2+(WORD_W+1+P)·DIV, where P=1 with parity, else 0.
- Register `done`, `frame_err` and `parity_err`, and `data_out`, on the clock after the stop sample. Return to IDLE on that same edge.
- Back-to-back frames: the next start bit can be detected on the first IDLE cycle. No dead time beyond that cycle.
- `done`, `frame_err` and `parity_err` are mutually exclusive and never high for two consecutive cycles.

## Configuration
- `DESER_PARITY_EN` defined: the frame carries one even-parity bit after the data bits, and the PARITY state is compiled in. `parity_err` is live. A mismatched word never raises `done`, so no memory write and no address advance.
- Not defined: frames are start + WORD_W + stop. PARITY state and logic are absent. `parity_err` is constant 0.

## Test plan
- Reset / idle line:
  - Stimulus: `reset` 3 cycles, `serial_in`=1, `enable`=1 for 5000 cycles.
  - Response: all outputs 0, `busy` never rises.
- Single word:
  - Stimulus: DIV=8, WORD_W=16, send 0xA5C3 LSB first with a valid stop bit.
  - Response: exactly one `done` pulse at t0+4+17·8+1, with `data_out`=0xA5C3. `busy` falls on the same edge.
- Glitch and frame error:
  - Stimulus: a 2-cycle low pulse on `serial_in` → no `busy` beyond START, no pulses. Then a frame 0x00FF with stop bit low → `frame_err` pulse, `data_out` keeps its prior value, no `done`.
- Back-to-back and abort:
  - Stimulus: three consecutive frames 0x0001, 0xFFFF, 0x8000 with no idle gap → three `done` pulses, correct data each time.
  - Stimulus: then drop `enable` mid-data-bit 7 of a fourth frame → IDLE next cycle, no pulse; the following full frame is received correctly.
- Mid-frame reset:
  - Stimulus: assert `reset` during DATA bit 10.
  - Response: `data_out`=0 and `busy`=0 next cycle; the next frame 0x1234 decodes correctly.
- Parity (`DESER_PARITY_EN` defined):
  - Stimulus: 0x0003 with parity bit 0 → `done`, `data_out`=0x0003.
  - Stimulus: 0x0007 with parity bit 0 → `parity_err` pulse, no `done`, `data_out` stays 0x0003.
